// File: rtl/mips_display_pkg.sv
// Shared constants and types for the result display slice.
// Holds digit count, blank pattern, the active-low hex segment table
// ({g,f,e,d,c,b,a}) and the registered output bundle type.
package mips_display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned DIG_IDX_W  = 3;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned DISP_W     = NUM_DIGITS * NIB_W;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-low segment patterns for hex digits 0..F.
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [DIG_IDX_W-1:0] digit_idx_t;

  // Registered display drive: anodes, cathodes, decimal point (all active-low).
  typedef struct packed {
    logic [NUM_DIGITS-1:0] an;
    logic [SEG_W-1:0]      seg;
    logic                  dp;
  } disp_out_t;

  localparam disp_out_t OUT_RESET = '{an: '1, seg: SEG_BLANK, dp: 1'b1};

endpackage

// File: rtl/result_display_ctrl_if.sv
// Bus between the pipeline/board and the display controller.
//   v0, v1 : 32-bit result registers to display
//   Sel    : raw push-button choosing v0 or v1
//   An     : active-low digit anodes (bit 0 = rightmost digit)
//   Seg    : active-low cathodes {g,f,e,d,c,b,a}
//   Dp     : active-low decimal point
// master = source of register values and button, slave = display controller.
interface result_display_ctrl_if;
  import mips_display_pkg::*;

  logic [DISP_W-1:0]     v0;
  logic [DISP_W-1:0]     v1;
  logic                  Sel;
  logic [NUM_DIGITS-1:0] An;
  logic [SEG_W-1:0]      Seg;
  logic                  Dp;

  modport master (
    output v0, v1, Sel,
    input  An, Seg, Dp
  );

  modport slave (
    input  v0, v1, Sel,
    output An, Seg, Dp
  );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational hex-to-7-segment decoder, active-low outputs.
//   i_nibble : 4-bit hex value
//   o_seg_c  : segments {g,f,e,d,c,b,a}, 0 = lit
module seg7_decoder
  import mips_display_pkg::*;
(
  input  logic [NIB_W-1:0] i_nibble,
  output logic [SEG_W-1:0] o_seg_c
);

  assign o_seg_c = HEX_SEG[i_nibble];

endmodule

// File: rtl/result_display_ctrl.sv
// Multiplexed 8-digit seven-segment display of $v0 / $v1.
// A debounced push-button toggles which register is shown; digits are
// scanned right to left, each held for REFRESH_DIV cycles. Dp on the
// rightmost digit marks that $v1 is displayed.
// Ports:
//   Clk : system clock, rising edge
//   Rst : synchronous active-low reset
//   bus : result_display_ctrl_if.slave (v0, v1, Sel in; An, Seg, Dp out)
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always shown).
module result_display_ctrl
  import mips_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 Clk,
  input  logic                 Rst,
  result_display_ctrl_if.slave bus
);

  localparam int unsigned DWELL_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(REFRESH_DIV - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

  logic              r_sel_meta;
  logic              r_sel_sync;
  logic              r_sel_stable;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_show_v1;
  logic [DISP_W-1:0] r_disp;
  logic [DWELL_W-1:0] r_dwell;
  digit_idx_t        r_digit;
  disp_out_t         r_out;

  logic [DB_W-1:0]    w_db_cnt_nxt;
  logic               w_stable_nxt;
  logic               w_show_v1_nxt;
  logic [DWELL_W-1:0] w_dwell_nxt;
  digit_idx_t         w_digit_nxt;
  logic [NIB_W-1:0]   w_nibble;
  logic [SEG_W-1:0]   w_seg_dec;
  logic               w_blank;
  disp_out_t          w_out_nxt;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_sel_meta <= 1'b0;
      r_sel_sync <= 1'b0;
    end else begin
      r_sel_meta <= bus.Sel;
      r_sel_sync <= r_sel_meta;
    end
  end

  // Debounce: accept a new level after it has differed for DEBOUNCE_CYCLES
  // consecutive cycles; only an accepted press (0->1) toggles the selection.
  always_comb begin
    w_db_cnt_nxt  = '0;
    w_stable_nxt  = r_sel_stable;
    w_show_v1_nxt = r_show_v1;
    if (r_sel_sync != r_sel_stable) begin
      if (r_db_cnt == DB_LAST) begin
        w_stable_nxt = r_sel_sync;
        if (r_sel_sync) begin
          w_show_v1_nxt = ~r_show_v1;
        end
      end else begin
        w_db_cnt_nxt = r_db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_db_cnt     <= '0;
      r_sel_stable <= 1'b0;
      r_show_v1    <= 1'b0;
    end else begin
      r_db_cnt     <= w_db_cnt_nxt;
      r_sel_stable <= w_stable_nxt;
      r_show_v1    <= w_show_v1_nxt;
    end
  end

  // Displayed value, re-sampled every cycle so live register changes show.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_disp <= '0;
    end else begin
      r_disp <= r_show_v1 ? bus.v1 : bus.v0;
    end
  end

  // Dwell counter and digit index; the 3-bit index wraps 7->0 naturally.
  always_comb begin
    w_dwell_nxt = r_dwell + DWELL_W'(1);
    w_digit_nxt = r_digit;
    if (r_dwell == DWELL_LAST) begin
      w_dwell_nxt = '0;
      w_digit_nxt = r_digit + DIG_IDX_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_dwell <= '0;
      r_digit <= '0;
    end else begin
      r_dwell <= w_dwell_nxt;
      r_digit <= w_digit_nxt;
    end
  end

  assign w_nibble = r_disp[NIB_W*r_digit +: NIB_W];

  seg7_decoder u_seg7_decoder (
    .i_nibble (w_nibble),
    .o_seg_c  (w_seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Blank digit i>0 when it and every more-significant nibble are zero.
  always_comb begin
    w_blank = (r_digit != '0);
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ((DIG_IDX_W'(i) >= r_digit) && (r_disp[NIB_W*i +: NIB_W] != '0)) begin
        w_blank = 1'b0;
      end
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  // Next display drive for the current digit.
  always_comb begin
    w_out_nxt     = OUT_RESET;
    w_out_nxt.an  = ~(NUM_DIGITS'(1) << r_digit);
    w_out_nxt.seg = w_blank ? SEG_BLANK : w_seg_dec;
    w_out_nxt.dp  = ~((r_digit == '0) && r_show_v1);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_out <= OUT_RESET;
    end else begin
      r_out <= w_out_nxt;
    end
  end

  assign bus.An  = r_out.an;
  assign bus.Seg = r_out.seg;
  assign bus.Dp  = r_out.dp;

endmodule
